// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: operation encodings,
// default widths, FSM state type and small op-decoding helpers.
package div_unit_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 6;

  // op[1] = unsigned, op[0] = remainder select
  localparam logic [1:0] DIV_OP_DIV_W  = 2'b00;
  localparam logic [1:0] DIV_OP_MOD_W  = 2'b01;
  localparam logic [1:0] DIV_OP_DIV_WU = 2'b10;
  localparam logic [1:0] DIV_OP_MOD_WU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[1];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
  import div_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0]   shifted_s;
  logic [XLEN+1:0] diff_s;
  logic            neg_s;

  // Trial subtract on the XLEN+1-bit shifted remainder; the extra top bit is the borrow.
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
    neg_s     = diff_s[XLEN+1];
    if (neg_s) begin
      rem_next = shifted_s[XLEN-1:0];
    end else begin
      rem_next = diff_s[XLEN-1:0];
    end
    quo_next = {quo[XLEN-2:0], ~neg_s};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
// Magnitudes are divided unsigned and sign-corrected at the end; divide by
// zero bypasses sign correction. Optional build macro DIV_FAST_PATH_EN lets
// b==0 and |a|<|b| skip the iterations and answer on the accepting edge.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data
);

  div_state_e      state_r, state_nx_s;
  logic            req_ready_r, rsp_valid_r;
  logic [XLEN-1:0] rsp_data_r;
  logic [XLEN-1:0] rem_r, quo_r, divisor_r, dividend_r;
  logic [CNT_W-1:0] cnt_r;
  logic            rem_sel_r, qsign_r, rsign_r, bzero_r;

  logic            accept_s, finish_s, fast_s;
  logic            a_neg_s, b_neg_s, b_zero_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN-1:0] rem_step_s, quo_step_s;

  // Final result selection: divide by zero skips sign correction entirely.
  function automatic logic [XLEN-1:0] pick_result(
    input logic            rem_sel,
    input logic            bzero,
    input logic            qsign,
    input logic            rsign,
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem,
    input logic [XLEN-1:0] dividend
  );
    logic [XLEN-1:0] r;
    if (bzero) begin
      r = rem_sel ? dividend : {XLEN{1'b1}};
    end else if (rem_sel) begin
      r = rsign ? (~rem + {{(XLEN-1){1'b0}}, 1'b1}) : rem;
    end else begin
      r = qsign ? (~quo + {{(XLEN-1){1'b0}}, 1'b1}) : quo;
    end
    return r;
  endfunction

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  // Operand magnitudes and the fast-path qualifier for an incoming request.
  always_comb begin
    a_neg_s  = op_is_signed(req_op) & req_a[XLEN-1];
    b_neg_s  = op_is_signed(req_op) & req_b[XLEN-1];
    a_mag_s  = a_neg_s ? (~req_a + {{(XLEN-1){1'b0}}, 1'b1}) : req_a;
    b_mag_s  = b_neg_s ? (~req_b + {{(XLEN-1){1'b0}}, 1'b1}) : req_b;
    b_zero_s = (req_b == {XLEN{1'b0}});
`ifdef DIV_FAST_PATH_EN
    fast_s   = b_zero_s | (a_mag_s < b_mag_s);
`else
    fast_s   = 1'b0;
`endif
  end

  // Next-state logic; flush wins in every state and blocks acceptance.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else if (req_valid && req_ready_r) begin
          accept_s   = 1'b1;
          state_nx_s = fast_s ? ST_DONE : ST_CALC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          finish_s   = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (flush || rsp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register plus the registered handshake flags derived from next state.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      req_ready_r <= (state_nx_s == ST_IDLE);
      rsp_valid_r <= (state_nx_s == ST_DONE);
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, capture the result.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      rem_r      <= {XLEN{1'b0}};
      quo_r      <= {XLEN{1'b0}};
      divisor_r  <= {XLEN{1'b0}};
      dividend_r <= {XLEN{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      rem_sel_r  <= 1'b0;
      qsign_r    <= 1'b0;
      rsign_r    <= 1'b0;
      bzero_r    <= 1'b0;
      rsp_data_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      rem_r      <= {XLEN{1'b0}};
      quo_r      <= a_mag_s;
      divisor_r  <= b_mag_s;
      dividend_r <= req_a;
      cnt_r      <= CNT_W'(XLEN);
      rem_sel_r  <= op_is_rem(req_op);
      qsign_r    <= a_neg_s ^ b_neg_s;
      rsign_r    <= a_neg_s;
      bzero_r    <= b_zero_s;
      if (fast_s) begin
        rsp_data_r <= pick_result(op_is_rem(req_op), b_zero_s, a_neg_s ^ b_neg_s,
                                  a_neg_s, {XLEN{1'b0}}, a_mag_s, req_a);
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end else if ((state_r == ST_CALC) && !flush) begin
      rem_r <= rem_step_s;
      quo_r <= quo_step_s;
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      if (finish_s) begin
        rsp_data_r <= pick_result(rem_sel_r, bzero_r, qsign_r, rsign_r,
                                  quo_step_s, rem_step_s, dividend_r);
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      cnt_r <= cnt_r;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every response handshake.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  div_unit dut (
    .cpu_clk  (clk),
    .cpu_rst  (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected edges from accept to rsp_valid, counting the accepting edge as 1.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef DIV_FAST_PATH_EN
    begin
      logic [31:0] am, bm;
      am = (!op[1] && a[31]) ? -a : a;
      bm = (!op[1] && b[31]) ? -b : b;
      if (b == 32'h0 || am < bm) lat = 1;
    end
`endif
    return lat;
  endfunction

  // Monitor: compare each response taken by the consumer against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got 0x%08h with empty scoreboard", rsp_data);
      end else begin
        check(name_q.pop_front(), rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_lat"}, n, exp_lat(op, a, b));
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);

    issue(2'b00, 32'd7,        32'd2,        32'h00000003, "divw_7_2");
    issue(2'b01, 32'd7,        32'd2,        32'h00000001, "modw_7_2");
    issue(2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "divw_m7_2");
    issue(2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "modw_m7_2");
    issue(2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, "modw_7_m2");
    issue(2'b10, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, "divwu_big");
    issue(2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, "modwu_big");
    issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "divw_ovf");
    issue(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "modw_ovf");
    issue(2'b00, 32'h12345678, 32'h0,        32'hFFFFFFFF, "divw_z");
    issue(2'b10, 32'h12345678, 32'h0,        32'hFFFFFFFF, "divwu_z");
    issue(2'b01, 32'h12345678, 32'h0,        32'h12345678, "modw_z");
    issue(2'b11, 32'h12345678, 32'h0,        32'h12345678, "modwu_z");
    issue(2'b00, 32'd3,        32'hFFFFFFFB, 32'h00000000, "divw_3_m5");
    issue(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFD, "modw_m3_5");

    // Consumer back-pressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(2'b10, 32'd50, 32'd5, 32'h0000000A, "hold_div");
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_data", rsp_data, 32'h0000000A);
      check("hold_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hold_ready", {31'h0, req_ready}, 32'h1);
    check("post_hold_valid", {31'h0, rsp_valid}, 32'h0);
    issue(2'b11, 32'd50, 32'd7, 32'h00000001, "after_hold");

    // Request alongside flush in IDLE must not be taken.
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'd9; req_b = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_ready", {31'h0, req_ready}, 32'h1);
    check("flush_req_valid", {31'h0, rsp_valid}, 32'h0);

    // Flush five cycles into CALC: no response may ever appear.
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'hFFFF0000; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'h0, req_ready}, 32'h1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (rsp_valid) seen++;
        @(posedge clk); #1;
      end
      check("flush_no_rsp", seen, 32'd0);
    end
    issue(2'b10, 32'd100, 32'd7, 32'h0000000E, "divwu_100_7");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
